// File: rtl/elevator_motor_drive_if.sv
// Target-floor command handshake between the request scheduler and the drive.
// The scheduler side is the master and the drive side is the slave.
interface elevator_motor_drive_if #(
  parameter int FLOOR_W = 2
);
  logic               cmd_valid;
  logic [FLOOR_W-1:0] cmd_floor;
  logic               cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_floor,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_floor,
    output cmd_ready
  );
endinterface

// File: rtl/elevator_motor_drive.sv
// Multi-floor elevator motor drive: dead time before first run and reversals,
// floor-by-floor travel on a tick time base, settle on arrival, estop halt.
module elevator_motor_drive #(
  parameter int FLOORS         = 4,
  parameter int FLOOR_W        = $clog2(FLOORS),
  parameter int TRAVEL_TICKS   = 8,
  parameter int DEADTIME_TICKS = 4,
  parameter int SETTLE_TICKS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               estop,
  elevator_motor_drive_if.slave cmd,
  output logic               motor_onoff,
  output logic               motor_dir,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               moving,
  output logic               arrived,
  output logic               cmd_err,
  output logic               halted
);

  localparam int MAX_TD =
    (TRAVEL_TICKS > DEADTIME_TICKS) ? TRAVEL_TICKS : DEADTIME_TICKS;
  localparam int MAX_T =
    (MAX_TD > SETTLE_TICKS) ? MAX_TD : SETTLE_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_T);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME_TICKS - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TRAVEL_TICKS - 1);
  localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [FLOOR_W:0] FLOOR_LIM = (FLOOR_W + 1)'(FLOORS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAD,
    S_RUN,
    S_SETTLE,
    S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d;
  logic [FLOOR_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               has_run_q, has_run_d;
  logic               last_dir_q, last_dir_d;
  logic               dir_q, dir_d;
  logic               arrived_q, arrived_d;
  logic               cmd_err_q, cmd_err_d;

  logic               accept;
  logic               req_bad;
  logic               req_same;
  logic               req_up;
  logic [CNT_W-1:0]   cnt_inc;
  logic [FLOOR_W-1:0] floor_nxt;

  assign accept   = cmd.cmd_valid && (state_q == S_IDLE);
  assign req_bad  = {1'b0, cmd.cmd_floor} >= FLOOR_LIM;
  assign req_same = cmd.cmd_floor == cur_floor_q;
  assign req_up   = cmd.cmd_floor > cur_floor_q;

  // Saturating count; the terminal compares keep it below CNT_MAX anyway.
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign floor_nxt = dir_q ? cur_floor_q + 1'b1
                           : cur_floor_q - 1'b1;

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    has_run_d   = has_run_q;
    last_dir_d  = last_dir_q;
    dir_d       = dir_q;
    arrived_d   = 1'b0;
    cmd_err_d   = 1'b0;

    if (estop) begin
      // Drop the move; the next one must start with dead time again.
      state_d   = S_HALT;
      cnt_d     = '0;
      has_run_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (req_bad) begin
              cmd_err_d = 1'b1;
            end else if (req_same) begin
              arrived_d = 1'b1;
            end else begin
              target_d = cmd.cmd_floor;
              dir_d    = req_up;
              cnt_d    = '0;
              if (!has_run_q || (req_up != last_dir_q)) begin
                state_d = S_DEAD;
              end else begin
                state_d = S_RUN;
              end
            end
          end
        end
        S_DEAD: begin
          if (tick) begin
            if (cnt_q == DEAD_LAST) begin
              state_d    = S_RUN;
              cnt_d      = '0;
              last_dir_d = dir_q;
              has_run_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_RUN: begin
          if (tick) begin
            if (cnt_q == RUN_LAST) begin
              cnt_d       = '0;
              cur_floor_d = floor_nxt;
              if (floor_nxt == target_q) begin
                state_d = S_SETTLE;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_SETTLE: begin
          if (tick) begin
            if (cnt_q == SET_LAST) begin
              state_d   = S_IDLE;
              cnt_d     = '0;
              arrived_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_HALT: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_floor_q <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      has_run_q   <= 1'b0;
      last_dir_q  <= 1'b0;
      dir_q       <= 1'b0;
      arrived_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      has_run_q   <= has_run_d;
      last_dir_q  <= last_dir_d;
      dir_q       <= dir_d;
      arrived_q   <= arrived_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign motor_onoff   = (state_q == S_RUN);
  assign motor_dir     = (state_q == S_RUN) && dir_q;
  assign moving        = (state_q == S_DEAD) || (state_q == S_RUN)
                      || (state_q == S_SETTLE);
  assign halted        = (state_q == S_HALT);
  assign cur_floor     = cur_floor_q;
  assign arrived       = arrived_q;
  assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_elevator_motor_drive.sv
// Directed bench for elevator_motor_drive with a completion scoreboard.
// Floor width is widened to 3 bits so out-of-range requests can be driven.
module tb_elevator_motor_drive;

  localparam int FW = 3;

  typedef struct {
    logic          is_err;
    logic [FW-1:0] floor;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          tick;
  logic          estop;
  logic          motor_onoff;
  logic          motor_dir;
  logic [FW-1:0] cur_floor;
  logic          moving;
  logic          arrived;
  logic          cmd_err;
  logic          halted;

  int            vectors = 0;
  int            miscompares = 0;
  exp_t          sb[$];
  logic [FW-1:0] model_floor;
  bit            gate = 1'b0;
  int            tph = 0;

  elevator_motor_drive_if #(.FLOOR_W(FW)) cif ();

  elevator_motor_drive #(
    .FLOORS         (4),
    .FLOOR_W        (FW),
    .TRAVEL_TICKS   (8),
    .DEADTIME_TICKS (4),
    .SETTLE_TICKS   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .estop       (estop),
    .cmd         (cif.slave),
    .motor_onoff (motor_onoff),
    .motor_dir   (motor_dir),
    .cur_floor   (cur_floor),
    .moving      (moving),
    .arrived     (arrived),
    .cmd_err     (cmd_err),
    .halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick = 1'b1;
    forever begin
      @(negedge clk);
      tph  = (tph == 2) ? 0 : tph + 1;
      tick = gate ? (tph == 0) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && (arrived === 1'b1 || cmd_err === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pulse", {30'd0, arrived, cmd_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_kind", {31'd0, cmd_err}, {31'd0, e.is_err});
        chk("sb_floor", {29'd0, cur_floor}, {29'd0, e.floor});
      end
    end
  end

  task automatic send_cmd(input logic [FW-1:0] f);
    chk("ready_before_cmd", {31'd0, cif.cmd_ready}, 32'd1);
    cif.cmd_valid = 1'b1;
    cif.cmd_floor = f;
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic quick_cmd(input logic [FW-1:0] f, input bit is_err);
    sb.push_back('{is_err, is_err ? model_floor : f});
    send_cmd(f);
    if (is_err) chk("cmd_err_pulse", {31'd0, cmd_err}, 32'd1);
    else chk("same_floor_arrived", {31'd0, arrived}, 32'd1);
    chk("quick_motor_off", {31'd0, motor_onoff}, 32'd0);
    chk("quick_not_moving", {31'd0, moving}, 32'd0);
    chk("quick_ready", {31'd0, cif.cmd_ready}, 32'd1);
    @(negedge clk);
    chk("pulse_one_cycle", {30'd0, arrived, cmd_err}, 32'd0);
  endtask

  task automatic run_move(input logic [FW-1:0] f, input int dmin,
                          input int dmax, input int nrun, input int nset,
                          input int seg);
    int dead = 0;
    int run = 0;
    int set = 0;
    int bad = 0;
    int cyc = 0;
    bit done = 1'b0;
    logic [FW-1:0] pf;
    logic dir;
    dir = (f > model_floor);
    pf  = model_floor;
    sb.push_back('{1'b0, f});
    send_cmd(f);
    while (!done && cyc < 3000) begin
      if (cur_floor !== pf) begin
        if (cur_floor !== (dir ? pf + 3'd1 : pf - 3'd1)) bad++;
        if (run == 0 || (run % seg) != 0) bad++;
        pf = cur_floor;
      end
      if (arrived === 1'b1) begin
        done = 1'b1;
        chk("ready_with_arrived", {31'd0, cif.cmd_ready}, 32'd1);
      end else if (motor_onoff === 1'b1) begin
        run++;
        if (motor_dir !== dir) bad++;
      end else begin
        if (motor_dir !== 1'b0) bad++;
        if (moving !== 1'b1) bad++;
        else if (run == 0) dead++;
        else set++;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("move_completed", {31'd0, done}, 32'd1);
    if (dmin == dmax) chk("dead_cycles", dead, dmin);
    else chk("dead_cycles_in_range", {31'd0, (dead >= dmin && dead <= dmax)}, 32'd1);
    chk("run_cycles", run, nrun);
    chk("settle_cycles", set, nset);
    chk("segment_and_dir_errors", bad, 0);
    chk("final_floor", {29'd0, cur_floor}, {29'd0, f});
    model_floor = f;
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    estop = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_floor = '0;
    model_floor = '0;
    @(negedge clk);
    chk("rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
    chk("rst_motor", {30'd0, motor_onoff, motor_dir}, 32'd0);
    chk("rst_floor", {29'd0, cur_floor}, 32'd0);
    chk("rst_flags", {28'd0, moving, arrived, cmd_err, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_move(3'd3, 4, 4, 24, 2, 8);
    run_move(3'd2, 4, 4, 8, 2, 8);
    run_move(3'd0, 0, 0, 16, 2, 8);

    quick_cmd(3'd5, 1'b1);
    quick_cmd(3'd0, 1'b0);

    estop = 1'b1;
    cif.cmd_valid = 1'b1;
    cif.cmd_floor = 3'd2;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("estop_prio_halted", {31'd0, halted}, 32'd1);
    chk("estop_prio_still", {30'd0, moving, motor_onoff}, 32'd0);
    estop = 1'b0;
    @(negedge clk);
    chk("estop_prio_idle", {30'd0, halted, moving}, 32'd0);
    chk("estop_prio_ready", {31'd0, cif.cmd_ready}, 32'd1);

    send_cmd(3'd3);
    cyc = 0;
    while (cur_floor !== 3'd1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_floor1_in_time", {31'd0, (cyc < 200)}, 32'd1);
    repeat (4) @(negedge clk);
    estop = 1'b1;
    @(negedge clk);
    chk("halt_motor_off", {31'd0, motor_onoff}, 32'd0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_floor", {29'd0, cur_floor}, 32'd1);
    chk("halt_not_ready", {30'd0, cif.cmd_ready, moving}, 32'd0);
    repeat (3) @(negedge clk);
    chk("halt_held", {31'd0, halted}, 32'd1);
    estop = 1'b0;
    @(negedge clk);
    chk("halt_released", {31'd0, halted}, 32'd0);
    model_floor = 3'd1;
    run_move(3'd3, 4, 4, 16, 2, 8);

    send_cmd(3'd0);
    cyc = 0;
    while (cur_floor !== 3'd2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_floor2_in_time", {31'd0, (cyc < 200)}, 32'd1);
    @(negedge clk);
    chk("mid_run_motor_on", {31'd0, motor_onoff}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_motor", {30'd0, motor_onoff, motor_dir}, 32'd0);
    chk("async_rst_floor", {29'd0, cur_floor}, 32'd0);
    chk("async_rst_flags", {28'd0, moving, arrived, cmd_err, halted}, 32'd0);
    chk("async_rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    model_floor = '0;
    gate = 1'b1;
    @(negedge clk);
    @(negedge clk);
    run_move(3'd1, 10, 12, 24, 6, 24);

    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elevator_motor_drive.md
# elevator_motor_drive

Parametrised multi-floor elevator motor drive. Accepts a target-floor command over a valid/ready handshake and moves the car floor by floor. Each floor segment takes a fixed number of time-base ticks. A motor-off dead time is inserted before the first run and before any direction reversal, and a settle period is inserted on arrival. Sits between the floor-request scheduler and the motor driver pins, and replaces the fixed two-floor motor control.

## Interface
Parameters:
- FLOORS, default 4: number of floors (≥2); floors numbered 0..FLOORS-1.
- FLOOR_W, default $clog2(FLOORS): floor index width.
- TRAVEL_TICKS, default 8: ticks per one-floor segment (≥1).
- DEADTIME_TICKS, default 4: motor-off ticks before the first run and before a reversal (≥1).
- SETTLE_TICKS, default 2: motor-off ticks after arrival before `arrived` (≥1).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- tick  in  1  one-cycle time-base strobe; all tick counts advance only on clk edges where tick=1.
- cmd_valid  in  1  target-floor request valid.
- cmd_floor  in  FLOOR_W  requested floor.
- cmd_ready  out  1  high only in IDLE; transfer occurs when cmd_valid & cmd_ready.
- estop  in  1  emergency stop, level-sensitive, highest priority.
- motor_onoff  out  1  1 = motor energised.
- motor_dir  out  1  1 = up, 0 = down; forced 0 whenever motor_onoff=0.
- cur_floor  out  FLOOR_W  last floor fully reached.
- moving  out  1  high in DEAD, RUN and SETTLE.
- arrived  out  1  one-cycle pulse when a command completes.
- cmd_err  out  1  one-cycle pulse when a command is rejected (cmd_floor ≥ FLOORS).
- halted  out  1  high while in HALT.

## Operation
States: IDLE, DEAD, RUN, SETTLE, HALT. All outputs are registered or decoded from registered state.
- Reset values: IDLE, cur_floor=0, target=0, tick counter=0, has_run=0, last_dir=0. All outputs 0 except cmd_ready=1.
- IDLE, on accept:
  - cmd_floor ≥ FLOORS: cmd_err pulse next cycle; stay IDLE.
  - cmd_floor == cur_floor: arrived pulse next cycle; stay IDLE; no motion.
  - Otherwise: latch target and dir = (cmd_floor > cur_floor).
    - If !has_run or dir != last_dir: go to DEAD.
    - Else: go to RUN.
- DEAD: motor off. After DEADTIME_TICKS ticks, go to RUN and set last_dir=dir, has_run=1.
- RUN: motor_onoff=1, motor_dir=dir. Count ticks.
  - On the TRAVEL_TICKS-th tick: cur_floor ±1 and counter clears (same edge).
  - If the new cur_floor == target: go to SETTLE; else stay in RUN for the next segment.
- SETTLE: motor off. After SETTLE_TICKS ticks: arrived pulse on the next cycle, and the state goes to IDLE on that same edge.
- estop=1 in any state:
  - Next edge goes to HALT: motor off, counter cleared, partial segment discarded, cur_floor unchanged, pending target dropped (no arrived).
  - HALT → IDLE on the first edge with estop=0.
  - has_run is cleared, so the next move always takes dead time.
  - estop has priority over a simultaneous accept: the command is ignored.
- cmd_valid outside IDLE: ignored, not queued.
- Counter width: $clog2(max(TRAVEL_TICKS, DEADTIME_TICKS, SETTLE_TICKS)+1). The counter saturates; it does not wrap.

## Timing
- Accept at edge E (cmd_valid & cmd_ready). The state changes at E; cmd_ready is low from E.
- With no dead time, motor_onoff is high in the cycle after E.
- Total motion length:
  - Dead time, when applied, is DEADTIME_TICKS ticks.
  - Travel is |target − start| × TRAVEL_TICKS ticks of motor_onoff high, then SETTLE_TICKS ticks.
- The cur_floor increment and the motor_onoff fall on the final segment happen on the same edge.
- arrived and cmd_err are exactly one clk cycle wide. cmd_ready rises on the same edge arrived is asserted.
- Reset assertion clears all outputs asynchronously, mid-motion included. Deassertion is synchronised externally.
- tick held high continuously is legal: one count per clk.

## Test plan
- After reset, cmd 0→3 with tick every cycle and defaults: 4 cycles DEAD, then motor_onoff=1 / motor_dir=1 for 24 ticks. cur_floor steps 1,2,3 at 8-tick intervals; then 2 ticks SETTLE; then one arrived pulse.
- Cmd 3→2 immediately after, up→down reversal: DEAD 4 ticks, then 8 ticks motor_dir=0, cur_floor=2, arrived. A follow-up cmd 2→0 has no DEAD and starts RUN the cycle after accept.
- cmd_floor=5 with FLOORS=4: cmd_err for one cycle, no motion. cmd_floor == cur_floor: arrived only, motor_onoff stays 0.
- estop at tick 5 of the second segment of 0→3: motor_onoff=0 next cycle, halted=1, cur_floor=1, no arrived. On release, the next cmd to 3 takes DEAD again.
- rst low during RUN: all outputs 0 and cur_floor=0 immediately, without waiting for a clk edge. tick gated to every 3rd cycle: segment length is 24 cycles.
